// File: rtl/register_bank.sv
// Register bank with one write port and two registered read ports; entry 0 is hardwired to zero.
// Define REGBANK_BYPASS_EN to forward same-edge write data to a read of the address being written.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif

module register_bank #(
    parameter int WIDTH  = `ARCH_WIDTH,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              hold,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic              rvalid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata_a;
    logic [WIDTH-1:0] r_rdata_b;
    logic             r_rvalid;

    logic             w_write;
    logic             w_read;
    logic [WIDTH-1:0] w_read_a;
    logic [WIDTH-1:0] w_read_b;

    assign w_write = we && !hold && (waddr != '0);
    assign w_read  = re && !hold;

    // Address 0 reads as zero regardless of what the storage entry contains.
    always_comb begin
        w_read_a = (raddr_a == '0) ? '0 : r_mem[raddr_a];
        w_read_b = (raddr_b == '0) ? '0 : r_mem[raddr_b];
`ifdef REGBANK_BYPASS_EN
        if (w_write && (waddr == raddr_a)) begin
            w_read_a = wdata;
        end
        if (w_write && (waddr == raddr_b)) begin
            w_read_b = wdata;
        end
`endif
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_write) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read data is only refreshed by an accepted read; otherwise the last result is held.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
            r_rvalid  <= 1'b0;
        end else if (!hold) begin
            r_rvalid <= re;
            if (w_read) begin
                r_rdata_a <= w_read_a;
                r_rdata_b <= w_read_b;
            end
        end
    end

    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;
    assign rvalid  = r_rvalid;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: a reference model pushes expected read data
// into queues when a read is issued and each test pops and compares one cycle later.
`timescale 1ns/1ps

module tb_register_bank;

    logic        clock;
    logic        clear;
    logic        hold;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [3:0]  raddr_a;
    logic [3:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        rvalid;

    logic [31:0] mdl [16];
    logic [31:0] expA [$];
    logic [31:0] expB [$];
    int          checks;
    int          errors;

    register_bank dut (
        .clock   (clock),
        .clear   (clear),
        .hold    (hold),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .rvalid  (rvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus, record the model's expected read result, then sample after the edge.
    task automatic step(input logic iwe, input logic [3:0] iwa, input logic [31:0] iwd,
                        input logic ire, input logic [3:0] ira, input logic [3:0] irb,
                        input logic ihold);
        logic [31:0] ea;
        logic [31:0] eb;
        @(negedge clock);
        we = iwe; waddr = iwa; wdata = iwd;
        re = ire; raddr_a = ira; raddr_b = irb; hold = ihold;
        if (ire && !ihold) begin
            ea = (ira == 4'd0) ? 32'd0 : mdl[ira];
            eb = (irb == 4'd0) ? 32'd0 : mdl[irb];
`ifdef REGBANK_BYPASS_EN
            if (iwe && iwa != 4'd0 && iwa == ira) ea = iwd;
            if (iwe && iwa != 4'd0 && iwa == irb) eb = iwd;
`endif
            expA.push_back(ea);
            expB.push_back(eb);
        end
        if (iwe && !ihold && iwa != 4'd0) mdl[iwa] = iwd;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b1; hold = 1'b0; we = 1'b0; re = 1'b0;
        waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
        #12;
        checks++; if (rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata_a got=%h want=%h", rdata_a, 32'd0); end
        checks++; if (rdata_b !== 32'd0) begin errors++; $display("[TB] FAIL reset_rdata_b got=%h want=%h", rdata_b, 32'd0); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rvalid got=%b want=0", rvalid); end
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        step(1'b1, 4'd3, 32'h0000FFFF, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd3, 1'b0);
        e = expA.pop_front();
        checks++; if (rdata_a !== e || rdata_a !== 32'h0000FFFF) begin errors++; $display("[TB] FAIL write_read_a got=%h want=%h", rdata_a, 32'h0000FFFF); end
        e = expB.pop_front();
        checks++; if (rdata_b !== e) begin errors++; $display("[TB] FAIL write_read_b got=%h want=%h", rdata_b, e); end
        checks++; if (rvalid !== 1'b1) begin errors++; $display("[TB] FAIL write_read_rvalid got=%b want=1", rvalid); end
    endtask

    task automatic test_zero_entry();
        logic [31:0] e;
        step(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd0, 4'd0, 1'b0);
        e = expA.pop_front();
        checks++; if (rdata_a !== e || rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL zero_entry_a got=%h want=%h", rdata_a, 32'd0); end
        e = expB.pop_front();
        checks++; if (rdata_b !== e || rdata_b !== 32'd0) begin errors++; $display("[TB] FAIL zero_entry_b got=%h want=%h", rdata_b, 32'd0); end
    endtask

    task automatic test_same_edge();
        logic [31:0] e;
        logic [31:0] want;
`ifdef REGBANK_BYPASS_EN
        want = 32'h12345678;
`else
        want = 32'h000000FF;
`endif
        step(1'b1, 4'd5, 32'h000000FF, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b1, 4'd5, 32'h12345678, 1'b1, 4'd3, 4'd5, 1'b0);
        e = expA.pop_front();
        checks++; if (rdata_a !== e) begin errors++; $display("[TB] FAIL same_edge_a got=%h want=%h", rdata_a, e); end
        e = expB.pop_front();
        checks++; if (rdata_b !== e || rdata_b !== want) begin errors++; $display("[TB] FAIL same_edge_b got=%h want=%h", rdata_b, want); end
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd5, 4'd5, 1'b0);
        e = expA.pop_front();
        checks++; if (rdata_a !== e || rdata_a !== 32'h12345678) begin errors++; $display("[TB] FAIL same_edge_later_a got=%h want=%h", rdata_a, 32'h12345678); end
        e = expB.pop_front();
        checks++; if (rdata_b !== e || rdata_b !== 32'h12345678) begin errors++; $display("[TB] FAIL same_edge_later_b got=%h want=%h", rdata_b, 32'h12345678); end
    endtask

    task automatic test_hold();
        logic [31:0] heldA;
        logic [31:0] heldB;
        logic [31:0] e;
        step(1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 4'd5, 1'b0);
        heldA = expA.pop_front();
        heldB = expB.pop_front();
        checks++; if (rdata_a !== heldA || rdata_b !== heldB) begin errors++; $display("[TB] FAIL hold_setup got=%h/%h want=%h/%h", rdata_a, rdata_b, heldA, heldB); end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 4'd7, 32'hAAAAAAAA, 1'b1, 4'd7, 4'd7, 1'b1);
            checks++; if (rdata_a !== heldA || rdata_b !== heldB || rvalid !== 1'b1) begin
                errors++; $display("[TB] FAIL hold_cycle%0d got=%h/%h/%b want=%h/%h/1", i, rdata_a, rdata_b, rvalid, heldA, heldB);
            end
        end
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 4'd7, 1'b0);
        e = expA.pop_front();
        checks++; if (rdata_a !== e || rdata_a !== 32'h00000077) begin errors++; $display("[TB] FAIL hold_entry7_a got=%h want=%h", rdata_a, 32'h00000077); end
        e = expB.pop_front();
        checks++; if (rdata_b !== e) begin errors++; $display("[TB] FAIL hold_entry7_b got=%h want=%h", rdata_b, e); end
    endtask

    task automatic test_rvalid_drop();
        logic [31:0] e;
        step(1'b1, 4'd2, 32'h0000BEEF, 1'b0, 4'd0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 32'd0, 1'b1, 4'd2, 4'd0, 1'b0);
        e = expA.pop_front();
        void'(expB.pop_front());
        checks++; if (rvalid !== 1'b1 || rdata_a !== e) begin errors++; $display("[TB] FAIL rvalid_rise got=%b/%h want=1/%h", rvalid, rdata_a, e); end
        step(1'b0, 4'd0, 32'd0, 1'b0, 4'd9, 4'd9, 1'b0);
        checks++; if (rvalid !== 1'b0) begin errors++; $display("[TB] FAIL rvalid_fall got=%b want=0", rvalid); end
        checks++; if (rdata_a !== 32'h0000BEEF) begin errors++; $display("[TB] FAIL rvalid_keep_a got=%h want=%h", rdata_a, 32'h0000BEEF); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        // Each write overlaps a read of the same and the previous address.
        for (int i = 1; i < 16; i++) begin
            step(1'b1, 4'(i), 32'(i), 1'b1, 4'(i), 4'(i - 1), 1'b0);
            e = expA.pop_front();
            checks++; if (rdata_a !== e) begin errors++; $display("[TB] FAIL b2b_a addr=%0d got=%h want=%h", i, rdata_a, e); end
            e = expB.pop_front();
            checks++; if (rdata_b !== e) begin errors++; $display("[TB] FAIL b2b_b addr=%0d got=%h want=%h", i - 1, rdata_b, e); end
        end
    endtask

    task automatic test_clear();
        logic [31:0] e;
        step(1'b1, 4'd4, 32'h44444444, 1'b1, 4'd15, 4'd14, 1'b0);
        void'(expA.pop_front());
        void'(expB.pop_front());
        // Pulse clear mid-cycle while a write and a read are being driven.
        @(negedge clock);
        we = 1'b1; waddr = 4'd6; wdata = 32'hFFFFFFFF; re = 1'b1; raddr_a = 4'd6; raddr_b = 4'd1;
        #1 clear = 1'b1;
        #1;
        checks++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0 || rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL clear_immediate got=%h/%h/%b want=0/0/0", rdata_a, rdata_b, rvalid);
        end
        @(posedge clock);
        #1;
        checks++; if (rvalid !== 1'b0 || rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL clear_priority got=%h/%b want=0/0", rdata_a, rvalid); end
        for (int i = 0; i < 16; i++) mdl[i] = 32'd0;
        @(negedge clock);
        clear = 1'b0; we = 1'b0; re = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'd0, 32'd0, 1'b1, 4'(i), 4'(15 - i), 1'b0);
            e = expA.pop_front();
            checks++; if (rdata_a !== e || rdata_a !== 32'd0) begin errors++; $display("[TB] FAIL clear_read_a addr=%0d got=%h want=0", i, rdata_a); end
            e = expB.pop_front();
            checks++; if (rdata_b !== e || rdata_b !== 32'd0) begin errors++; $display("[TB] FAIL clear_read_b addr=%0d got=%h want=0", 15 - i, rdata_b); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_zero_entry();
        test_same_edge();
        test_hold();
        test_rvalid_drop();
        test_back_to_back();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
